// File: rtl/pc_fetch_stage_pkg.sv
// Shared types and constants for the MIPS fetch stage: FSM encoding,
// next-PC select codes and fixed fetch constants.
package pc_fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL    = 2'd1,
    ST_REDIRECT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEL_HOLD   = 2'd0,
    SEL_SEQ    = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_BRANCH = 2'd3
  } pc_sel_e;

  localparam logic [31:0] NOP_ENC = 32'h0000_0000;
  localparam logic [31:0] PC_INC  = 32'd4;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational fetch-address arithmetic: PC+4, branch and jump targets,
// and the prioritised next-PC selection.
module pc_target_calc
  import pc_fetch_stage_pkg::*;
(
  input  logic [31:0]  pc,
  input  logic [31:0]  ifid_pc_plus4,
  input  logic [31:0]  branch_offset,
  input  logic [25:0]  jump_index,
  input  fetch_state_e state,
  input  logic         stall,
  input  logic         jump,
  input  logic         branch_taken,
  output logic [31:0]  pc_plus4,
  output logic [31:0]  branch_target,
  output logic [31:0]  jump_target,
  output logic [31:0]  next_pc,
  output pc_sel_e      sel
);

  logic signed [31:0] offset_s;
  logic signed [31:0] base_s;

  assign offset_s      = branch_offset;
  assign base_s        = ifid_pc_plus4;
  assign pc_plus4      = pc + PC_INC;
  assign branch_target = $unsigned(base_s + offset_s);
  assign jump_target   = {ifid_pc_plus4[31:28], jump_index, 2'b00};

  // While ID holds a squashed bubble, its redirect requests are stale.
  always_comb begin
    sel = SEL_SEQ;
    if (stall)                      sel = SEL_HOLD;
    else if (state == ST_REDIRECT)  sel = SEL_SEQ;
    else if (jump)                  sel = SEL_JUMP;
    else if (branch_taken)          sel = SEL_BRANCH;
  end

  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      SEL_HOLD:   next_pc = pc;
      SEL_SEQ:    next_pc = pc_plus4;
      SEL_JUMP:   next_pc = jump_target;
      SEL_BRANCH: next_pc = branch_target;
      default:    next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// PC register, IF/ID pipeline register and redirect FSM for a 5-stage MIPS.
// Optional performance counters are enabled with `define PC_FETCH_PERF_EN.
module pc_fetch_stage
  import pc_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic        jump_i,
  input  logic [31:0] branch_offset_i,
  input  logic [25:0] jump_index_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc_plus4_o,
  output logic [31:0] branch_target_o,
  output logic        redirect_o
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [31:0] redirect_count_o,
  output logic [31:0] stall_count_o
`endif
);

  fetch_state_e state, state_next;
  pc_sel_e      sel;
  logic [31:0]  pc_p0;
  logic [31:0]  ifid_instr_p1;
  logic [31:0]  ifid_pc_plus4_p1;
  logic [31:0]  pc_plus4;
  logic [31:0]  jump_target;
  logic [31:0]  next_pc;
  logic         squash;

  pc_target_calc u_calc (
    .pc            (pc_p0),
    .ifid_pc_plus4 (ifid_pc_plus4_p1),
    .branch_offset (branch_offset_i),
    .jump_index    (jump_index_i),
    .state         (state),
    .stall         (stall_i),
    .jump          (jump_i),
    .branch_taken  (branch_taken_i),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target_o),
    .jump_target   (jump_target),
    .next_pc       (next_pc),
    .sel           (sel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = ST_RUN;
    case (sel)
      SEL_HOLD:   state_next = (state == ST_REDIRECT) ? ST_REDIRECT : ST_STALL;
      SEL_JUMP,
      SEL_BRANCH: state_next = ST_REDIRECT;
      default:    state_next = ST_RUN;
    endcase
  end

  always_comb begin
    redirect_o = (state == ST_REDIRECT);
    squash     = (sel == SEL_JUMP) || (sel == SEL_BRANCH);
  end

  // IF -> ID boundary: PC advances and the fetched word enters IF/ID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_p0            <= RESET_PC;
      ifid_instr_p1    <= NOP_INSTR;
      ifid_pc_plus4_p1 <= 32'd0;
    end else if (sel != SEL_HOLD) begin
      pc_p0            <= next_pc;
      ifid_instr_p1    <= squash ? NOP_INSTR : instr_i;
      ifid_pc_plus4_p1 <= pc_plus4;
    end
  end

  assign pc_o            = pc_p0;
  assign ifid_instr_o    = ifid_instr_p1;
  assign ifid_pc_plus4_o = ifid_pc_plus4_p1;

`ifdef PC_FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_count_o <= 32'd0;
      stall_count_o    <= 32'd0;
    end else begin
      if (squash)  redirect_count_o <= redirect_count_o + 32'd1;
      if (stall_i) stall_count_o    <= stall_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: sequential fetch, branch/jump redirect,
// stalls, redirect-state behaviour and asynchronous reset.
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        branch_taken_i;
  logic        jump_i;
  logic [31:0] branch_offset_i;
  logic [25:0] jump_index_i;
  logic [31:0] instr_i;
  logic [31:0] pc_o;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc_plus4_o;
  logic [31:0] branch_target_o;
  logic        redirect_o;
`ifdef PC_FETCH_PERF_EN
  logic [31:0] redirect_count_o;
  logic [31:0] stall_count_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .jump_i          (jump_i),
    .branch_offset_i (branch_offset_i),
    .jump_index_i    (jump_index_i),
    .instr_i         (instr_i),
    .pc_o            (pc_o),
    .ifid_instr_o    (ifid_instr_o),
    .ifid_pc_plus4_o (ifid_pc_plus4_o),
    .branch_target_o (branch_target_o),
    .redirect_o      (redirect_o)
`ifdef PC_FETCH_PERF_EN
    ,
    .redirect_count_o (redirect_count_o),
    .stall_count_o    (stall_count_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall_i = 1'b0; branch_taken_i = 1'b0; jump_i = 1'b0;
    branch_offset_i = 32'd0; jump_index_i = 26'd0; instr_i = 32'h2108_0001;
    step(); step();
    check("rst_pc", pc_o, 32'h0);
    check("rst_instr", ifid_instr_o, 32'h0);
    check("rst_pc4", ifid_pc_plus4_o, 32'h0);
    check("rst_redirect", {31'd0, redirect_o}, 32'd0);
    @(negedge clk); reset = 1'b0;

    // sequential fetch
    step();
    check("seq1_pc", pc_o, 32'h4);
    check("seq1_pc4", ifid_pc_plus4_o, 32'h4);
    check("seq1_instr", ifid_instr_o, 32'h2108_0001);
    step(); check("seq2_pc", pc_o, 32'h8);
    step(); check("seq3_pc", pc_o, 32'hC);
    step();
    check("seq4_pc", pc_o, 32'h10);
    check("seq4_pc4", ifid_pc_plus4_o, 32'h10);

    // backward taken branch to 0
    branch_offset_i = 32'hFFFF_FFF0; branch_taken_i = 1'b1;
    #1 check("br_target", branch_target_o, 32'h0);
    step();
    check("br_pc", pc_o, 32'h0);
    check("br_instr_nop", ifid_instr_o, 32'h0);
    check("br_pc4", ifid_pc_plus4_o, 32'h14);
    check("br_redirect", {31'd0, redirect_o}, 32'd1);
    instr_i = 32'hAAAA_0000;
    step();
    check("redir_ign_pc", pc_o, 32'h4);
    check("redir_target_instr", ifid_instr_o, 32'hAAAA_0000);
    check("redir_pc4", ifid_pc_plus4_o, 32'h4);
    check("redir_drop", {31'd0, redirect_o}, 32'd0);
    branch_taken_i = 1'b0;
    #1 check("br_wrap", branch_target_o, 32'hFFFF_FFF4);

    // branch into the 0x4xxx_xxxx region
    branch_offset_i = 32'h4000_0000; branch_taken_i = 1'b1;
    step();
    check("br2_pc", pc_o, 32'h4000_0004);
    branch_taken_i = 1'b0;
    step();
    check("br2_seq_pc", pc_o, 32'h4000_0008);
    check("br2_seq_pc4", ifid_pc_plus4_o, 32'h4000_0008);

    // jump and branch together: jump wins
    jump_i = 1'b1; branch_taken_i = 1'b1; jump_index_i = 26'h000_0040;
    branch_offset_i = 32'h0000_0100;
    step();
    check("jmp_pc", pc_o, 32'h4000_0100);
    check("jmp_instr_nop", ifid_instr_o, 32'h0);
    check("jmp_pc4", ifid_pc_plus4_o, 32'h4000_000C);
    check("jmp_redirect", {31'd0, redirect_o}, 32'd1);
    jump_i = 1'b0; branch_taken_i = 1'b0;
    step();
    check("jmp_seq_pc", pc_o, 32'h4000_0104);
    check("jmp_seq_pc4", ifid_pc_plus4_o, 32'h4000_0104);

    // stall with a pending branch
    stall_i = 1'b1; branch_taken_i = 1'b1; branch_offset_i = 32'h10;
    instr_i = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc_o, 32'h4000_0104);
      check("stall_pc4", ifid_pc_plus4_o, 32'h4000_0104);
      check("stall_instr", ifid_instr_o, 32'hAAAA_0000);
      check("stall_redirect", {31'd0, redirect_o}, 32'd0);
    end
    stall_i = 1'b0;
    step();
    check("post_stall_pc", pc_o, 32'h4000_0114);
    check("post_stall_redirect", {31'd0, redirect_o}, 32'd1);

    // stall while in REDIRECT holds everything
    stall_i = 1'b1; branch_taken_i = 1'b0;
    step();
    check("redir_stall_pc", pc_o, 32'h4000_0114);
    check("redir_stall_flag", {31'd0, redirect_o}, 32'd1);
    stall_i = 1'b0;
    step();
    check("redir_release_pc", pc_o, 32'h4000_0118);
    check("redir_release_flag", {31'd0, redirect_o}, 32'd0);

    // asynchronous reset in the middle of a REDIRECT cycle
    branch_taken_i = 1'b1;
    step();
    branch_taken_i = 1'b0;
    check("final_br_pc", pc_o, 32'h4000_0128);
    check("final_br_redirect", {31'd0, redirect_o}, 32'd1);
`ifdef PC_FETCH_PERF_EN
    check("perf_redirects", redirect_count_o, 32'd5);
    check("perf_stalls", stall_count_o, 32'd4);
`endif
    #2 reset = 1'b1;
    #1;
    check("async_rst_pc", pc_o, 32'h0);
    check("async_rst_instr", ifid_instr_o, 32'h0);
    check("async_rst_pc4", ifid_pc_plus4_o, 32'h0);
    check("async_rst_redirect", {31'd0, redirect_o}, 32'd0);
`ifdef PC_FETCH_PERF_EN
    check("async_rst_rcnt", redirect_count_o, 32'd0);
    check("async_rst_scnt", stall_count_o, 32'd0);
`endif
    @(negedge clk); reset = 1'b0;
    step();
    check("after_rst_pc", pc_o, 32'h4);
    check("after_rst_instr", ifid_instr_o, 32'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
